// File: rtl/ctrl_broadcast_if.sv
// rtl/ctrl_broadcast_if.sv - upstream word and per-lane handshake bundle for ctrl_broadcast
interface ctrl_broadcast_if #(
   parameter int DIMENSION            = 3,
   parameter int MATRIX_ELEMENT_WIDTH = 8
);
   logic [MATRIX_ELEMENT_WIDTH-1:0]           in_data;
   logic                                      in_valid;
   logic                                      in_ready;
   logic [DIMENSION-1:0]                      lane_enable;
   logic [0:DIMENSION*MATRIX_ELEMENT_WIDTH-1] out;
   logic [DIMENSION-1:0]                      out_valid;
   logic [DIMENSION-1:0]                      out_ready;

   modport master (
      output in_data, in_valid, lane_enable, out_ready,
      input  in_ready, out, out_valid
   );

   modport slave (
      input  in_data, in_valid, lane_enable, out_ready,
      output in_ready, out, out_valid
   );
endinterface

// File: rtl/ctrl_broadcast.sv
// rtl/ctrl_broadcast.sv - broadcasts one control word to DIMENSION lanes, holding it until every enabled lane takes it
module ctrl_broadcast #(
   parameter int DIMENSION            = 3,
   parameter int MATRIX_ELEMENT_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ctrl_broadcast_if.slave   bus,
   output logic              busy,
   output logic              done,
   output logic [15:0]       bcast_cnt
);
   typedef enum logic {IDLE, BCAST} state_t;

   state_t                          state_q, state_d;
   logic [MATRIX_ELEMENT_WIDTH-1:0] data_q, data_d;
   logic [DIMENSION-1:0]            pending_q, pending_d;
   logic                            done_q, done_d;
   logic [15:0]                     bcast_cnt_q, bcast_cnt_d;

   logic [DIMENSION-1:0] pending_left;
   logic                 accept;
   logic                 complete_old;
   logic                 complete_new;
   logic [1:0]           n_complete;

   // Lanes still owed the word after this cycle's lane handshakes.
   assign pending_left = pending_q & ~bus.out_ready;
   assign bus.in_ready = (state_q == IDLE) || (pending_left == '0);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      pending_d    = pending_q;
      done_d       = 1'b0;
      complete_old = 1'b0;
      complete_new = 1'b0;

      if (state_q == BCAST) begin
         pending_d = pending_left;
         if (pending_left == '0) begin
            complete_old = 1'b1;
            state_d      = IDLE;
         end
      end

      if (accept) begin
         data_d    = bus.in_data;
         pending_d = bus.lane_enable;
         if (bus.lane_enable == '0) begin
            complete_new = 1'b1;
            state_d      = IDLE;
         end else begin
            state_d = BCAST;
         end
      end

      // A retiring broadcast and an empty-mask word can both complete on one edge.
      n_complete  = {1'b0, complete_old} + {1'b0, complete_new};
      done_d      = complete_old || complete_new;
      bcast_cnt_d = bcast_cnt_q + {14'd0, n_complete};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         pending_q   <= '0;
         done_q      <= 1'b0;
         bcast_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         bcast_cnt_q <= bcast_cnt_d;
      end
   end

   assign bus.out       = {DIMENSION{data_q}};
   assign bus.out_valid = pending_q;
   assign busy          = (state_q == BCAST);
   assign done          = done_q;
   assign bcast_cnt     = bcast_cnt_q;
endmodule

// File: tb/tb_ctrl_broadcast.sv
// tb/tb_ctrl_broadcast.sv - directed self-checking bench for ctrl_broadcast
module tb_ctrl_broadcast;
   localparam int D = 3;
   localparam int W = 8;

   logic        clk;
   logic        rst_n;
   logic        busy;
   logic        done;
   logic [15:0] bcast_cnt;

   int n_tests;
   int n_fail;

   ctrl_broadcast_if #(.DIMENSION(D), .MATRIX_ELEMENT_WIDTH(W)) bus ();

   ctrl_broadcast #(.DIMENSION(D), .MATRIX_ELEMENT_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .busy      (busy),
      .done      (done),
      .bcast_cnt (bcast_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.in_data     = '0;
      bus.in_valid    = 1'b0;
      bus.lane_enable = '0;
      bus.out_ready   = '0;
      #3;
      n_tests++; if (bus.out !== 24'h000000) begin n_fail++; $display("FAIL reset_out got %h want 000000", bus.out); end
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b want 000", bus.out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_tests++; if (bcast_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", bcast_cnt); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bus.in_data     = 8'hA5;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b111;
      bus.out_ready   = 3'b111;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out !== 24'hA5A5A5) begin n_fail++; $display("FAIL basic_out got %h want a5a5a5", bus.out); end
      n_tests++; if (bus.out_valid !== 3'b111) begin n_fail++; $display("FAIL basic_valid got %b want 111", bus.out_valid); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early got %b want 0", done); end
      tick();
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL basic_valid_clr got %b want 000", bus.out_valid); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
      n_tests++; if (bcast_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt got %0d want 1", bcast_cnt); end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
   endtask

   task automatic test_staggered();
      logic [2:0] rdy_tab   [1:5] = '{3'b001, 3'b001, 3'b101, 3'b101, 3'b111};
      logic [2:0] valid_tab [1:5] = '{3'b111, 3'b110, 3'b110, 3'b010, 3'b010};
      logic       irdy_tab  [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bus.in_data     = 8'h3C;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b111;
      bus.out_ready   = 3'b000;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         bus.out_ready = rdy_tab[c];
         #1;
         n_tests++; if (bus.out_valid !== valid_tab[c]) begin n_fail++; $display("FAIL stag_valid c%0d got %b want %b", c, bus.out_valid, valid_tab[c]); end
         n_tests++; if (bus.in_ready !== irdy_tab[c]) begin n_fail++; $display("FAIL stag_in_ready c%0d got %b want %b", c, bus.in_ready, irdy_tab[c]); end
         n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL stag_done c%0d got %b want 0", c, done); end
         tick();
      end
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL stag_valid_end got %b want 000", bus.out_valid); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stag_done_end got %b want 1", done); end
      n_tests++; if (bcast_cnt !== 16'd2) begin n_fail++; $display("FAIL stag_cnt got %0d want 2", bcast_cnt); end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL stag_done_once got %b want 0", done); end
   endtask

   task automatic test_partial_empty();
      bus.in_data     = 8'h11;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b101;
      bus.out_ready   = 3'b000;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out_valid !== 3'b101) begin n_fail++; $display("FAIL part_valid got %b want 101", bus.out_valid); end
      n_tests++; if (bus.out[0 +: W] !== 8'h11) begin n_fail++; $display("FAIL part_data got %h want 11", bus.out[0 +: W]); end
      tick();
      n_tests++; if (bus.out_valid !== 3'b101) begin n_fail++; $display("FAIL part_hold got %b want 101", bus.out_valid); end
      bus.out_ready = 3'b111;
      tick();
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL part_clr got %b want 000", bus.out_valid); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL part_done got %b want 1", done); end
      n_tests++; if (bcast_cnt !== 16'd3) begin n_fail++; $display("FAIL part_cnt got %0d want 3", bcast_cnt); end
      tick();
      bus.in_data     = 8'h22;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b000;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL empty_valid got %b want 000", bus.out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done got %b want 1", done); end
      n_tests++; if (bcast_cnt !== 16'd4) begin n_fail++; $display("FAIL empty_cnt got %0d want 4", bcast_cnt); end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse got %b want 0", done); end
   endtask

   task automatic test_back_to_back();
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b111;
      bus.out_ready   = 3'b111;
      for (int i = 1; i <= 4; i++) begin
         bus.in_data = 8'(i);
         #1;
         n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready w%0d got %b want 1", i, bus.in_ready); end
         tick();
         n_tests++; if (bus.out[0 +: W] !== 8'(i)) begin n_fail++; $display("FAIL b2b_data w%0d got %h want %h", i, bus.out[0 +: W], 8'(i)); end
         n_tests++; if (bus.out_valid !== 3'b111) begin n_fail++; $display("FAIL b2b_valid w%0d got %b want 111", i, bus.out_valid); end
         n_tests++; if (done !== (i > 1)) begin n_fail++; $display("FAIL b2b_done w%0d got %b want %b", i, done, (i > 1)); end
      end
      bus.in_valid = 1'b0;
      tick();
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_last got %b want 1", done); end
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_valid_end got %b want 000", bus.out_valid); end
      n_tests++; if (bcast_cnt !== 16'd8) begin n_fail++; $display("FAIL b2b_cnt got %0d want 8", bcast_cnt); end
   endtask

   task automatic test_reset_mid();
      bus.in_data     = 8'h5A;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b110;
      bus.out_ready   = 3'b000;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out_valid !== 3'b110) begin n_fail++; $display("FAIL rmid_pre got %b want 110", bus.out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL rmid_valid got %b want 000", bus.out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_tests++; if (bus.out !== 24'h000000) begin n_fail++; $display("FAIL rmid_out got %h want 000000", bus.out); end
      n_tests++; if (bcast_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d want 0", bcast_cnt); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
      #2;
      rst_n = 1'b1;
      bus.in_data     = 8'h77;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b111;
      bus.out_ready   = 3'b111;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.out !== 24'h777777) begin n_fail++; $display("FAIL rmid_next_out got %h want 777777", bus.out); end
      tick();
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmid_next_done got %b want 1", done); end
      n_tests++; if (bcast_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_next_cnt got %0d want 1", bcast_cnt); end
   endtask

   task automatic test_wrap();
      force dut.bcast_cnt_q = 16'hFFFF;
      #1;
      release dut.bcast_cnt_q;
      bus.in_data     = 8'h99;
      bus.in_valid    = 1'b1;
      bus.lane_enable = 3'b000;
      tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bcast_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt got %h want 0000", bcast_cnt); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_basic();
      test_staggered();
      test_partial_empty();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ctrl_broadcast.md
# ctrl_broadcast

Global-controller broadcaster that takes one control word from a single upstream source and delivers it to `DIMENSION` processing-element lanes. Each lane has its own valid/ready handshake, and the block holds the word until every enabled lane has accepted it. It is the distribution counterpart of the global OR-reduction: it drives a packed lane vector with the same layout that the reduction consumes, so the two blocks bracket the PE array on the controller side.

## Interface
- `DIMENSION`, 3: number of lanes.
- `MATRIX_ELEMENT_WIDTH`, 8: width of one control word in bits.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  `MATRIX_ELEMENT_WIDTH`: word to broadcast.
- `in_valid`  in  1: upstream word present.
- `in_ready`  out  1: block can accept a word this cycle.
- `lane_enable`  in  `DIMENSION`: bit i=1 means lane i must receive the word. Sampled only on acceptance.
- `out`  out  `[0:DIMENSION*MATRIX_ELEMENT_WIDTH-1]`: packed lane data. Lane i occupies `out[i*MATRIX_ELEMENT_WIDTH +: MATRIX_ELEMENT_WIDTH]`.
- `out_valid`  out  `DIMENSION`: lane i holds an undelivered word.
- `out_ready`  in  `DIMENSION`: lane i accepts this cycle.
- `busy`  out  1: a broadcast is outstanding.
- `done`  out  1: one-cycle pulse when a broadcast completes.
- `bcast_cnt`  out  16: number of completed broadcasts, wraps at 2^16.

## Operation
- State registers:
  - `state` ∈ {IDLE, BCAST}.
  - `data_q` (`MATRIX_ELEMENT_WIDTH` bits).
  - `pending` (`DIMENSION` bits).
  - `done`, `bcast_cnt`.
- Reset (async, `rst_n`=0), effective immediately and independent of `clk`:
  - `state`=IDLE, `data_q`=0, `pending`=0, `done`=0, `bcast_cnt`=0.
  - Outputs therefore read `out`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
  - A broadcast in progress is dropped and is not counted.
- `out` replicates `data_q` onto every lane. `out_valid` = `pending`. `busy` = (`state`==BCAST).
- Acceptance: `in_valid` && `in_ready` at a rising edge.
  - Load `data_q` from `in_data`.
  - Load `pending` from `lane_enable`.
  - If `lane_enable`≠0, go to BCAST.
  - If `lane_enable`==0, the word completes immediately: stay in (or return to) IDLE, pulse `done`, increment `bcast_cnt`.
- BCAST:
  - Each edge clears `pending[i]` where `out_valid[i]` && `out_ready[i]`.
  - When `pending` reaches 0 with no new acceptance in the same edge: go to IDLE, pulse `done`, increment `bcast_cnt`.
- `in_ready` (combinational): asserted when either condition holds:
  - `state`==IDLE, or
  - `(pending & ~out_ready)`==0, i.e. every remaining lane accepts this cycle.
  - This allows back-to-back broadcasts with no bubble.
- Simultaneous completion and acceptance at one edge:
  - The old broadcast counts as completed (`done` pulses, `bcast_cnt` increments).
  - The new word loads and the state follows the acceptance rule.
- Stability while `out_valid[i]`=1: the lane-i data is stable and `out_valid[i]` never drops until handshaken. Changes to `lane_enable` during BCAST are ignored.
- `out_ready[i]` for a lane with `out_valid[i]`=0 has no effect.
- `bcast_cnt` wraps 0xFFFF→0x0000 without a flag.

## Timing
- Acceptance at edge k: `out_valid` and `out` are valid from just after edge k, i.e. in cycle k+1.
- Lane handshake at edge m clears that lane's `out_valid` in cycle m+1.
- `done` is registered and high exactly for the cycle after the completing edge. `bcast_cnt` updates on that same edge.
- Best-case throughput, with all enabled lanes always ready: one broadcast per cycle.
- No combinational path from `in_data` to `out`. The only combinational output is `in_ready`, which depends on `state`, `pending` and `out_ready`.

## Test plan
- Basic broadcast:
  - Stimulus: reset; DIMENSION=3, W=8; `lane_enable`=3'b111; send 0xA5 with all `out_ready`=1.
  - Required: `out`=0xA5A5A5 and `out_valid`=111 for one cycle; `done` the next cycle; `bcast_cnt`=1.
- Staggered ready:
  - Stimulus: send 0x3C; `out_ready` goes high on lane 0 at cycle 1, lane 2 at cycle 3, lane 1 at cycle 5.
  - Required:
    - `out_valid` steps 111→110→010→000 (bit i = lane i).
    - `in_ready`=0 in cycles 1-4 and 1 in cycle 5 (fall-through).
    - `done` exactly once.
- Partial and empty mask:
  - Stimulus: `lane_enable`=3'b101 with word 0x11, then `lane_enable`=0 with word 0x22.
  - Required: for 0x11, lane 1 never sees valid. For 0x22, no `out_valid` and `done` pulses the cycle after acceptance. `bcast_cnt` +2 overall.
- Back-to-back:
  - Stimulus: 4 words 0x01..0x04 on consecutive cycles, all lanes ready.
  - Required: `in_ready` constantly 1; `out` lane data sequence 01,02,03,04; 4 consecutive `done` pulses.
- Reset mid-operation:
  - Stimulus: deassert `rst_n` asynchronously (between edges) while lanes 1 and 2 are pending.
  - Required: `out_valid`=0, `busy`=0 and `out`=0 immediately; `bcast_cnt`=0; the next accepted word broadcasts normally.
- Counter wrap:
  - Stimulus: force `bcast_cnt` to 0xFFFF, then complete one broadcast.
  - Required: `bcast_cnt`=0x0000.
